// File: rtl/hyst_detect_pkg.sv
// Shared definitions for the hysteresis event detector: FSM encoding and
// sizing of the dwell counter.
package hyst_detect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ACTIVE   = 2'd2,
    QUAL_OFF = 2'd3
  } hyst_state_t;

  // Largest legal DWELL; the dwell counter is sized to hold it.
  localparam int DWELL_MAX   = 255;
  localparam int DWELL_W     = $clog2(DWELL_MAX + 1);
  // One extra bit so that count+1 can be compared against DWELL without overflow.
  localparam int DWELL_CMP_W = DWELL_W + 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear and inc together load 1,
// which lets the first sample of a run both restart and count itself.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = clear ? '0 : count_reg;
    if (inc && (count_next != '1)) begin
      count_next = count_next + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hyst_detect.sv
// Hysteresis event detector on a smoothed sample stream: declares an event after
// DWELL on-samples, ends it after DWELL off-samples, and reports peak and length.
module hyst_detect
  import hyst_detect_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0,
  parameter int DWELL  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic             active,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] peak,
  output logic [CNT_W-1:0] duration
);

  localparam logic [DWELL_CMP_W-1:0] DWELL_TARGET = DWELL_CMP_W'(DWELL);
  localparam bit DWELL_ONE = (DWELL == 1);

  hyst_state_t      state_reg;
  logic [WIDTH-1:0] peak_run_reg;
  logic             active_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic [WIDTH-1:0] peak_reg;
  logic [CNT_W-1:0] duration_reg;

  logic             on_hit;
  logic             off_hit;
  logic             above_peak;
  logic [WIDTH-1:0] peak_with_sample;

  logic [DWELL_W-1:0]     dwell_count;
  logic [DWELL_CMP_W-1:0] dwell_plus;
  logic                   dwell_done;
  logic                   dwell_clear;
  logic                   dwell_inc;

  logic [CNT_W-1:0] dur_count;
  logic [CNT_W-1:0] dur_plus;
  logic             dur_clear;
  logic             dur_inc;

  generate
    if (SIGNED != 0) begin : g_signed_cmp
      assign on_hit     = $signed(idata) >= $signed(thr_hi);
      assign off_hit    = $signed(idata) <  $signed(thr_lo);
      assign above_peak = $signed(idata) >  $signed(peak_run_reg);
    end else begin : g_unsigned_cmp
      assign on_hit     = idata >= thr_hi;
      assign off_hit    = idata <  thr_lo;
      assign above_peak = idata >  peak_run_reg;
    end
  endgenerate

  assign peak_with_sample = above_peak ? idata : peak_run_reg;

  // dwell_count holds the qualifying samples seen so far; the current one makes it +1.
  assign dwell_plus = {1'b0, dwell_count} + DWELL_CMP_W'(1);
  assign dwell_done = dwell_plus >= DWELL_TARGET;

  // The final event sample is not yet in the counter when the event ends.
  assign dur_plus = (dur_count == '1) ? dur_count : dur_count + 1'b1;

  always_comb begin
    dwell_clear = 1'b0;
    dwell_inc   = 1'b0;
    dur_clear   = 1'b0;
    dur_inc     = 1'b0;
    if (ivalid) begin
      unique case (state_reg)
        IDLE: begin
          dwell_clear = 1'b1;
          dwell_inc   = on_hit && !DWELL_ONE;
          dur_clear   = on_hit;
          dur_inc     = on_hit;
        end
        QUAL_ON: begin
          dwell_clear = !on_hit || dwell_done;
          dwell_inc   = on_hit && !dwell_done;
          dur_clear   = !on_hit;
          dur_inc     = on_hit;
        end
        ACTIVE: begin
          dwell_clear = 1'b1;
          dwell_inc   = off_hit && !DWELL_ONE;
          dur_clear   = off_hit && DWELL_ONE;
          dur_inc     = !(off_hit && DWELL_ONE);
        end
        QUAL_OFF: begin
          dwell_clear = !off_hit || dwell_done;
          dwell_inc   = off_hit && !dwell_done;
          dur_clear   = off_hit && dwell_done;
          dur_inc     = !(off_hit && dwell_done);
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(DWELL_W)
  ) u_dwell (
    .clock(clock),
    .reset(reset),
    .clear(dwell_clear),
    .inc  (dwell_inc),
    .count(dwell_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_duration (
    .clock(clock),
    .reset(reset),
    .clear(dur_clear),
    .inc  (dur_inc),
    .count(dur_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      peak_run_reg <= '0;
      active_reg   <= 1'b0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      peak_reg     <= '0;
      duration_reg <= '0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (ivalid) begin
        unique case (state_reg)
          IDLE: begin
            if (on_hit) begin
              peak_run_reg <= idata;
              if (DWELL_ONE) begin
                state_reg  <= ACTIVE;
                active_reg <= 1'b1;
                rise_reg   <= 1'b1;
              end else begin
                state_reg <= QUAL_ON;
              end
            end
          end
          QUAL_ON: begin
            if (on_hit) begin
              peak_run_reg <= peak_with_sample;
              if (dwell_done) begin
                state_reg  <= ACTIVE;
                active_reg <= 1'b1;
                rise_reg   <= 1'b1;
              end
            end else begin
              state_reg <= IDLE;
            end
          end
          ACTIVE: begin
            peak_run_reg <= peak_with_sample;
            if (off_hit) begin
              if (DWELL_ONE) begin
                state_reg    <= IDLE;
                active_reg   <= 1'b0;
                fall_reg     <= 1'b1;
                peak_reg     <= peak_with_sample;
                duration_reg <= dur_plus;
              end else begin
                state_reg <= QUAL_OFF;
              end
            end
          end
          QUAL_OFF: begin
            peak_run_reg <= peak_with_sample;
            if (off_hit) begin
              if (dwell_done) begin
                state_reg    <= IDLE;
                active_reg   <= 1'b0;
                fall_reg     <= 1'b1;
                peak_reg     <= peak_with_sample;
                duration_reg <= dur_plus;
              end
            end else begin
              state_reg <= ACTIVE;
            end
          end
        endcase
      end
    end
  end

  assign active   = active_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;
  assign peak     = peak_reg;
  assign duration = duration_reg;

endmodule

// File: doc/hyst_detect.md
HYST_DETECT -- requirements
Module: hyst_detect

Interface
REQ-001 Parameter WIDTH, default 32: sample width; matches the upstream moving-average WIDTH.
REQ-002 Parameter SIGNED, default 0: 1 means samples and thresholds are two's complement; 0 means unsigned.
REQ-003 Parameter DWELL, default 4, legal range 1..255: consecutive qualifying valid samples required to change state.
REQ-004 Parameter CNT_W, default 16: duration counter width.
REQ-005 Port clock, input, 1: single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port idata, input, WIDTH: smoothed sample; connects directly to upstream odata.
REQ-008 Port ivalid, input, 1: idata qualifier; connects directly to upstream ovalid.
REQ-009 Port thr_hi, input, WIDTH: turn-on threshold; quasi-static.
REQ-010 Port thr_lo, input, WIDTH: turn-off threshold; quasi-static.
REQ-011 Port active, output, 1: level; high while an event is declared.
REQ-012 Port rise, output, 1: one-cycle pulse when an event is declared.
REQ-013 Port fall, output, 1: one-cycle pulse when an event ends.
REQ-014 Port peak, output, WIDTH: maximum sample of the last completed event; valid when fall is high, held afterwards.
REQ-015 Port duration, output, CNT_W: valid-sample count of the last completed event; valid when fall is high, held afterwards.

Function
REQ-016 State advances only on cycles with ivalid=1; on ivalid=0 cycles, state, counters and outputs other than the pulses SHALL hold.
REQ-017 Comparisons SHALL be signed when SIGNED=1 and unsigned otherwise.
REQ-018 On-condition is idata >= thr_hi. Off-condition is idata < thr_lo.
REQ-019 FSM states SHALL be IDLE, QUAL_ON, ACTIVE and QUAL_OFF.
REQ-020 IDLE: an on-sample SHALL load dwell=1 and go to QUAL_ON; if DWELL=1, go directly to ACTIVE.
REQ-021 QUAL_ON: an on-sample SHALL increment dwell and go to ACTIVE when dwell reaches DWELL; any other valid sample SHALL return to IDLE and clear dwell.
REQ-022 ACTIVE: an off-sample SHALL behave as in REQ-020, mirrored (dwell=1, go to QUAL_OFF; if DWELL=1, end the event immediately); any other sample SHALL stay in ACTIVE.
REQ-023 QUAL_OFF: an off-sample SHALL increment dwell and end the event, returning to IDLE, at DWELL; any other valid sample SHALL return to ACTIVE and clear dwell.
REQ-024 Event membership: the event SHALL start at the first qualifying on-sample of the successful QUAL_ON run and end at the last off-sample.
REQ-025 Peak and duration SHALL include every event sample, including the QUAL_ON and QUAL_OFF samples.
REQ-026 Duration SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 All outputs SHALL be registered with 1-cycle latency: rise or fall is high in the cycle after the ivalid cycle carrying the deciding sample.
REQ-028 active SHALL change in the same cycle as rise or fall.
REQ-029 rise and fall SHALL never be asserted in the same cycle.
REQ-030 A new event SHALL never start in the cycle its predecessor ends.
REQ-031 If thr_lo > thr_hi, the FSM SHALL still follow REQ-020..023 as written; no special handling is required.

Reset
REQ-032 Reset SHALL force IDLE, dwell=0 and an internal peak/duration clear, and drive active=0, rise=0, fall=0, peak=0, duration=0 on the next edge.
REQ-033 Reset mid-event SHALL NOT produce a fall pulse, and the aborted event's peak and duration SHALL be discarded.
REQ-034 Reset SHALL take priority over a simultaneous ivalid.

Structure
REQ-035 Package hyst_detect_pkg SHALL hold the FSM state enum and the saturating-increment width constants.
REQ-036 Sub-module sat_counter (parameter CNT_W; ports clear, inc, count) SHALL implement both the duration counter and the dwell counter.
REQ-037 The comparators and the peak register SHALL reside in hyst_detect.

Verification
Scenarios 1-5 use WIDTH=32, SIGNED=0, DWELL=2, thr_hi=10, thr_lo=5.
REQ-038 Scenario 1: valid samples 3,12,13 -> rise and active=1 one cycle after the ivalid of 13; no pulse earlier.
REQ-039 Scenario 2: 12,4,12,13 -> no rise after the first 12; rise only after 13.
REQ-040 Scenario 3: event from scenario 1, then 20,8,4,7,4,3 -> the 7 cancels QUAL_OFF. Fall follows the 3, with peak=20 and duration=8 (12,13,20,8,4,7,4,3); active returns to 0.
REQ-041 Scenario 4: scenario 1 with 3 idle cycles between each valid sample -> same outputs, delayed only by the gaps.
REQ-042 Scenario 5: CNT_W=4, 20 valid samples of 15 after rise, then 2,2 -> fall with duration=15.
REQ-043 Scenario 6: reset asserted while active=1 -> all outputs 0 next cycle, no fall; SIGNED=1, thr_hi=-3, thr_lo=-8, samples -2,-1 -> rise.
